// File: rtl/c432_key_loader_pkg.sv
// Shared definitions for the c432 key loader: default widths, FSM state type
// and the folded-XOR checksum used to validate a received key frame.
package c432_key_pkg;

  localparam int KEY_W_DEF    = 12;
  localparam int CHK_W_DEF    = 4;
  localparam int MAX_FAIL_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // XOR of every CHK_W-wide slice of the key.
  function automatic logic [CHK_W_DEF-1:0] chk_fold(input logic [KEY_W_DEF-1:0] k);
    logic [CHK_W_DEF-1:0] acc;
    acc = '0;
    for (int i = 0; i < KEY_W_DEF / CHK_W_DEF; i++) begin
      acc = acc ^ k[i*CHK_W_DEF +: CHK_W_DEF];
    end
    return acc;
  endfunction

endpackage

// File: rtl/c432_key_loader_if.sv
// Serial key-delivery handshake between the tester/secure memory (master)
// and the key loader (slave).
interface c432_key_loader_if;
    logic load_start;
    logic sdi_valid;
    logic sdi_bit;
    logic sdi_ready;

    modport master (output load_start, output sdi_valid, output sdi_bit, input sdi_ready);
    modport slave  (input load_start, input sdi_valid, input sdi_bit, output sdi_ready);
endinterface

// File: rtl/c432_key_loader_shreg.sv
// Serial-in shift register with accepted-bit counter for one key+checksum frame.
module c432_key_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             frame_full
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        // A restart wins over a bit arriving in the same cycle, dropping that bit.
        if (clear) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            data_d = {data_q[WIDTH-2:0], bit_in};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // High in the cycle whose accepted bit completes the frame.
    assign frame_full = shift_en && !clear && (cnt_q == CNT_W'(WIDTH - 1));
    assign data       = data_q;

endmodule

// File: rtl/c432_key_loader.sv
// Key loader for the locked c432 core: collects a serial key frame, verifies its
// folded-XOR checksum and applies the key atomically; repeated bad frames lock it out.
module c432_key_loader
    import c432_key_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int CHK_W    = CHK_W_DEF,
    parameter int MAX_FAIL = MAX_FAIL_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    c432_key_loader_if.slave    bus,
    output logic [KEY_W-1:0]    key,
    output logic                key_valid,
    output logic                load_done,
    output logic                load_err,
    output logic                locked_out
);
    localparam int FRAME_W = KEY_W + CHK_W;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic             locked_out_q, locked_out_d;
    logic [3:0]       fail_cnt_q, fail_cnt_d, fail_inc;

    logic [FRAME_W-1:0] frame;
    logic               frame_full, accept, clear, chk_ok, sdi_ready;

    assign sdi_ready = (state_q == ST_SHIFT);
    assign accept    = bus.sdi_valid && sdi_ready;
    assign clear     = bus.load_start && ((state_q == ST_IDLE) || (state_q == ST_SHIFT));

    c432_key_shreg #(.WIDTH(FRAME_W)) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .shift_en   (accept),
        .bit_in     (bus.sdi_bit),
        .data       (frame),
        .frame_full (frame_full)
    );

    assign chk_ok   = (chk_fold(frame[FRAME_W-1:CHK_W]) == frame[CHK_W-1:0]);
    assign fail_inc = (fail_cnt_q >= 4'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        locked_out_d = locked_out_q;
        fail_cnt_d   = fail_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!bus.load_start && frame_full) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_ok) begin
                    key_d       = frame[FRAME_W-1:CHK_W];
                    key_valid_d = 1'b1;
                    load_done_d = 1'b1;
                    fail_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    load_err_d = 1'b1;
                    fail_cnt_d = fail_inc;
                    // Lockout blanks the key bus so the core never runs with a stale key.
                    if (fail_inc == 4'(MAX_FAIL)) begin
                        key_d        = '0;
                        key_valid_d  = 1'b0;
                        locked_out_d = 1'b1;
                        state_d      = ST_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            locked_out_q <= locked_out_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign bus.sdi_ready = sdi_ready;
    assign key           = key_q;
    assign key_valid     = key_valid_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;
    assign locked_out    = locked_out_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_c432_key_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] key;
    logic        key_valid, load_done, load_err, locked_out;

    c432_key_loader_if bus ();

    c432_key_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .key        (key),
        .key_valid  (key_valid),
        .load_done  (load_done),
        .load_err   (load_err),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the loader should present after each frame.
    logic [11:0] m_key;
    logic        m_valid, m_locked, exp_done, exp_err;
    int          m_fail;

    function automatic logic [3:0] ref_fold(input logic [11:0] k);
        return k[11:8] ^ k[7:4] ^ k[3:0];
    endfunction

    task automatic model_reset();
        m_key = 12'h000; m_valid = 1'b0; m_locked = 1'b0; m_fail = 0;
        exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_frame(input logic [11:0] k, input logic [3:0] c);
        exp_done = 1'b0; exp_err = 1'b0;
        if (m_locked) return;
        if (ref_fold(k) == c) begin
            m_key = k; m_valid = 1'b1; m_fail = 0; exp_done = 1'b1;
        end else begin
            exp_err = 1'b1;
            m_fail++;
            if (m_fail >= 3) begin
                m_locked = 1'b1; m_key = 12'h000; m_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    // Drive the top n bits of w, MSB first, with 0..gapmax idle cycles before each bit.
    task automatic send_bits(input logic [15:0] w, input int n, input int gapmax);
        for (int i = 15; i > 15 - n; i--) begin
            int gap;
            gap = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            bus.sdi_valid = 1'b0;
            repeat (gap) @(negedge clk);
            bus.sdi_valid = 1'b1;
            bus.sdi_bit   = w[i];
            @(negedge clk);
        end
        bus.sdi_valid = 1'b0;
        bus.sdi_bit   = 1'b0;
    endtask

    task automatic test_reset();
        bus.load_start = 1'b0; bus.sdi_valid = 1'b0; bus.sdi_bit = 1'b0;
        do_reset();
        n_checks++;
        if ({key, key_valid, load_done, load_err, locked_out, bus.sdi_ready} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_state: got key=%h vld=%b done=%b err=%b lock=%b rdy=%b, required all zero",
                     key, key_valid, load_done, load_err, locked_out, bus.sdi_ready);
        end
    endtask

    task automatic test_good_frame();
        pulse_start();
        n_checks++;
        if (bus.sdi_ready !== 1'b1) begin
            n_fail++; $display("FAIL t1_ready: got %b required 1", bus.sdi_ready);
        end
        send_bits({12'hA5C, 4'h3}, 16, 0);
        model_frame(12'hA5C, 4'h3);
        n_checks++;
        if (bus.sdi_ready !== 1'b0 || load_done !== 1'b0) begin
            n_fail++; $display("FAIL t1_check_cycle: rdy=%b done=%b required 0 0", bus.sdi_ready, load_done);
        end
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || key !== 12'hA5C || key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_apply: done=%b err=%b key=%h vld=%b required 1 0 a5c 1", load_done, load_err, key, key_valid);
        end
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b0) begin
            n_fail++; $display("FAIL t1_done_pulse: got %b required 0", load_done);
        end
    endtask

    task automatic test_bad_frame();
        pulse_start();
        send_bits({12'h123, 4'h1}, 16, 0);
        model_frame(12'h123, 4'h1);
        @(negedge clk);
        n_checks++;
        if (load_err !== 1'b1 || load_done !== 1'b0 || key !== 12'hA5C || key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_bad: err=%b done=%b key=%h vld=%b required 1 0 a5c 1", load_err, load_done, key, key_valid);
        end
        @(negedge clk);
        n_checks++;
        if (load_err !== 1'b0) begin
            n_fail++; $display("FAIL t2_err_pulse: got %b required 0", load_err);
        end
    endtask

    task automatic test_lockout();
        int guard;
        int seen_done;
        guard = 0;
        while (!m_locked && guard < 3) begin
            logic [11:0] k;
            k = 12'($urandom);
            pulse_start();
            send_bits({k, ref_fold(k) ^ 4'h6}, 16, 1);
            model_frame(k, ref_fold(k) ^ 4'h6);
            @(negedge clk);
            n_checks++;
            if (load_err !== 1'b1 || locked_out !== m_locked || key !== m_key || key_valid !== m_valid) begin
                n_fail++;
                $display("FAIL t3_bad_%0d: err=%b lock=%b key=%h vld=%b required 1 %b %h %b",
                         guard, load_err, locked_out, key, key_valid, m_locked, m_key, m_valid);
            end
            @(negedge clk);
            guard++;
        end
        pulse_start();
        seen_done = 0;
        for (int i = 15; i >= 0; i--) begin
            bus.sdi_valid = 1'b1;
            bus.sdi_bit   = i[0];
            if (bus.sdi_ready !== 1'b0 || load_done !== 1'b0) seen_done++;
            @(negedge clk);
        end
        bus.sdi_valid = 1'b0;
        repeat (3) begin
            if (load_done !== 1'b0 || load_err !== 1'b0) seen_done++;
            @(negedge clk);
        end
        n_checks++;
        if (seen_done != 0 || locked_out !== 1'b1 || key !== 12'h000 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_locked: activity=%0d lock=%b key=%h vld=%b required 0 1 000 0",
                     seen_done, locked_out, key, key_valid);
        end
        do_reset();
        n_checks++;
        if (locked_out !== 1'b0 || key !== 12'h000) begin
            n_fail++; $display("FAIL t3_reset_clears: lock=%b key=%h required 0 000", locked_out, key);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        send_bits(16'h5A00, 7, 0);
        // Restart with a valid bit in the same cycle; that bit must be dropped.
        bus.load_start = 1'b1; bus.sdi_valid = 1'b1; bus.sdi_bit = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b0; bus.sdi_valid = 1'b0;
        send_bits({12'hFFF, 4'hF}, 16, 0);
        model_frame(12'hFFF, 4'hF);
        n_checks++;
        if (bus.sdi_ready !== 1'b0) begin
            n_fail++; $display("FAIL t4_count: rdy=%b required 0 after 16 bits", bus.sdi_ready);
        end
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || key !== 12'hFFF || key_valid !== 1'b1) begin
            n_fail++; $display("FAIL t4_restart: done=%b key=%h vld=%b required 1 fff 1", load_done, key, key_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_valid_gaps();
        pulse_start();
        send_bits({12'h800, 4'h8}, 16, 3);
        model_frame(12'h800, 4'h8);
        n_checks++;
        if (load_done !== 1'b0 || key !== 12'hFFF) begin
            n_fail++; $display("FAIL t5_early: done=%b key=%h required 0 fff", load_done, key);
        end
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || key !== 12'h800) begin
            n_fail++; $display("FAIL t5_latency: done=%b key=%h required 1 800", load_done, key);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_bits(16'hBEEF, 9, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({key, key_valid, load_done, load_err, locked_out, bus.sdi_ready} !== 17'h0) begin
            n_fail++;
            $display("FAIL t6_async: key=%h vld=%b done=%b err=%b lock=%b rdy=%b required all zero",
                     key, key_valid, load_done, load_err, locked_out, bus.sdi_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_bits({12'h001, 4'h1}, 16, 0);
        model_frame(12'h001, 4'h1);
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || key !== 12'h001 || key_valid !== 1'b1) begin
            n_fail++; $display("FAIL t6_reload: done=%b key=%h vld=%b required 1 001 1", load_done, key, key_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 16; f++) begin
            logic [11:0] k;
            logic [3:0]  c;
            k = 12'($urandom);
            c = ($urandom_range(9, 0) < 5) ? ref_fold(k) : ref_fold(k) ^ 4'($urandom_range(15, 1));
            if (m_locked && $urandom_range(1, 0) == 1) do_reset();
            pulse_start();
            send_bits({k, c}, 16, 2);
            model_frame(k, c);
            n_checks++;
            if (bus.sdi_ready !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_check_cycle_%0d: rdy=%b done=%b err=%b required 0 0 0",
                         f, bus.sdi_ready, load_done, load_err);
            end
            @(negedge clk);
            n_checks++;
            if (load_done !== exp_done || load_err !== exp_err || key !== m_key ||
                key_valid !== m_valid || locked_out !== m_locked) begin
                n_fail++;
                $display("FAIL rnd_frame_%0d: done=%b err=%b key=%h vld=%b lock=%b required %b %b %h %b %b",
                         f, load_done, load_err, key, key_valid, locked_out,
                         exp_done, exp_err, m_key, m_valid, m_locked);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_lockout();
        test_restart();
        test_valid_gaps();
        test_async_reset();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
